// File: rtl/dual_issue_scheduler.sv
// Dual-issue front-end scheduler: buffers fetched instruction pairs and issues
// up to two per cycle in program order, holding back the younger on hazards.
module dual_issue_scheduler #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_instr0,
  input  logic [W-1:0] in_instr1,
  output logic         in_ready,
  input  logic         flush,
  input  logic         stall,
  output logic         iss0_valid,
  output logic [W-1:0] iss0_instr,
  output logic         iss1_valid,
  output logic [W-1:0] iss1_instr
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic       rdRs;
    logic       rdRt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       mem;
    logic       br;
    logic       solo;
    logic       isLw;
  } dec_t;

  // A destination of $0 is encoded as "no write" so hazard checks can ignore it.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d    = '0;
    d.rs = ins[25:21];
    d.rt = ins[20:16];
    case (ins[31:26])
      6'b000000: begin d.rdRs = 1'b1; d.rdRt = 1'b1; d.dst = ins[15:11]; end
      6'b100011: begin d.rdRs = 1'b1; d.dst = ins[20:16]; d.mem = 1'b1; d.isLw = 1'b1; end
      6'b101011: begin d.rdRs = 1'b1; d.rdRt = 1'b1; d.mem = 1'b1; end
      6'b000100, 6'b000101: begin d.rdRs = 1'b1; d.rdRt = 1'b1; d.br = 1'b1; end
      6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110: begin
        d.rdRs = 1'b1;
        d.dst  = ins[20:16];
      end
      default: d.solo = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic readsReg(input dec_t d, input logic [4:0] r);
    return (d.rdRs && d.rs == r) || (d.rdRt && d.rt == r);
  endfunction

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [4:0]    r_ldRd;
  logic          r_ldV;

  logic [AW-1:0] w_headP1;
  logic [AW-1:0] w_tailP1;
  dec_t          w_dh;
  dec_t          w_dy;
  logic          w_loadUse;
  logic          w_pairBlock;
  logic          w_enq;
  logic [1:0]    w_nDeq;
  logic          w_newLdV;
  logic [4:0]    w_newLdRd;

  assign w_headP1 = r_head + AW'(1);
  assign w_tailP1 = r_tail + AW'(1);
  assign w_dh     = decode(r_mem[r_head][31:0]);
  assign w_dy     = decode(r_mem[w_headP1][31:0]);

  // Issue decision is purely a function of the head pair and the pending load.
  always_comb begin
    w_loadUse   = r_ldV && readsReg(w_dh, r_ldRd);
    w_pairBlock = ((w_dh.dst != 5'd0) && readsReg(w_dy, w_dh.dst))
               || ((w_dh.dst != 5'd0) && (w_dh.dst == w_dy.dst))
               || (w_dh.mem && w_dy.mem)
               || w_dh.br || w_dy.br
               || w_dh.solo || w_dy.solo
               || (r_ldV && readsReg(w_dy, r_ldRd));
    iss0_valid  = (r_count != '0) && !w_loadUse;
    iss1_valid  = iss0_valid && (r_count >= (AW+1)'(2)) && !w_pairBlock;
    iss0_instr  = r_mem[r_head];
    iss1_instr  = r_mem[w_headP1];
    in_ready    = r_count <= (AW+1)'(DEPTH-2);
    w_enq       = in_valid && in_ready && !flush;
    w_nDeq      = {1'b0, iss0_valid} + {1'b0, iss1_valid};
    w_newLdV    = 1'b0;
    w_newLdRd   = 5'd0;
    if (iss1_valid && w_dy.isLw && w_dy.dst != 5'd0) begin
      w_newLdV  = 1'b1;
      w_newLdRd = w_dy.dst;
    end else if (iss0_valid && w_dh.isLw && w_dh.dst != 5'd0) begin
      w_newLdV  = 1'b1;
      w_newLdRd = w_dh.dst;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_mem[r_tail]   <= in_instr0;
      r_mem[w_tailP1] <= in_instr1;
    end
  end

  // Flush beats stall; enqueue still proceeds while the back end is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_ldV   <= 1'b0;
      r_ldRd  <= 5'd0;
    end else if (flush) begin
      r_count <= '0;
      r_head  <= r_tail;
      r_ldV   <= 1'b0;
    end else begin
      if (w_enq) r_tail <= r_tail + AW'(2);
      if (!stall) begin
        r_head <= r_head + AW'(w_nDeq);
        r_ldV  <= w_newLdV;
        r_ldRd <= w_newLdRd;
      end
      r_count <= r_count + (w_enq ? (AW+1)'(2) : (AW+1)'(0))
                         - (stall ? (AW+1)'(0) : (AW+1)'(w_nDeq));
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Randomized and directed bench for dual_issue_scheduler against a queue-based
// reference model of the issue rules.
module tb_dual_issue_scheduler;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_instr0;
  logic [W-1:0] in_instr1;
  logic         in_ready;
  logic         flush;
  logic         stall;
  logic         iss0_valid;
  logic [W-1:0] iss0_instr;
  logic         iss1_valid;
  logic [W-1:0] iss1_instr;

  int tests = 0;
  int fails = 0;

  logic [31:0] q[$];
  bit          mLdV;
  logic [4:0]  mLdRd;

  dual_issue_scheduler #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr0(in_instr0),
    .in_instr1(in_instr1), .in_ready(in_ready), .flush(flush), .stall(stall),
    .iss0_valid(iss0_valid), .iss0_instr(iss0_instr),
    .iss1_valid(iss1_valid), .iss1_instr(iss1_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isKnown(input logic [31:0] ins);
    case (ins[31:26])
      6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] srcMask(input logic [31:0] ins);
    logic [31:0] m;
    m = 32'd0;
    case (ins[31:26])
      6'h00, 6'h2b, 6'h04, 6'h05: begin m[ins[25:21]] = 1'b1; m[ins[20:16]] = 1'b1; end
      6'h23, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e: m[ins[25:21]] = 1'b1;
      default: m = 32'd0;
    endcase
    return m;
  endfunction

  function automatic int dstOf(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: return int'(ins[15:11]);
      6'h23, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e: return int'(ins[20:16]);
      default: return 0;
    endcase
  endfunction

  function automatic bit isMem(input logic [31:0] ins);
    return ins[31:26] == 6'h23 || ins[31:26] == 6'h2b;
  endfunction

  function automatic bit isBr(input logic [31:0] ins);
    return ins[31:26] == 6'h04 || ins[31:26] == 6'h05;
  endfunction

  // Expected issue decision straight from the in-order dual-issue rules.
  task automatic computeExp(output bit e0, output bit e1);
    logic [31:0] h, y, ym;
    int d;
    bit block;
    e0 = 1'b0;
    e1 = 1'b0;
    if (q.size() >= 1) begin
      h  = q[0];
      e0 = !(mLdV && srcMask(h)[mLdRd]);
      if (e0 && q.size() >= 2) begin
        y     = q[1];
        ym    = srcMask(y);
        d     = dstOf(h);
        block = (d != 0 && ym[d]) || (d != 0 && d == dstOf(y))
             || (isMem(h) && isMem(y)) || isBr(h) || isBr(y)
             || !isKnown(h) || !isKnown(y) || (mLdV && ym[mLdRd]);
        e1    = !block;
      end
    end
  endtask

  task automatic modelUpdate();
    bit e0, e1, rdy, nv;
    int n;
    logic [4:0] nrd;
    computeExp(e0, e1);
    rdy = q.size() <= DEPTH - 2;
    if (reset) begin
      q.delete();
      mLdV  = 1'b0;
      mLdRd = 5'd0;
    end else if (flush) begin
      q.delete();
      mLdV = 1'b0;
    end else begin
      if (!stall) begin
        n   = int'(e0) + int'(e1);
        nv  = 1'b0;
        nrd = 5'd0;
        for (int k = 0; k < n; k++)
          if (q[k][31:26] == 6'h23 && q[k][20:16] != 5'd0) begin
            nv  = 1'b1;
            nrd = q[k][20:16];
          end
        mLdV  = nv;
        mLdRd = nrd;
        repeat (n) void'(q.pop_front());
      end
      if (in_valid && rdy) begin
        q.push_back(in_instr0);
        q.push_back(in_instr1);
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit e0, e1;
    computeExp(e0, e1);
    checkVal("iss0_valid", 32'(iss0_valid), 32'(e0));
    checkVal("iss1_valid", 32'(iss1_valid), 32'(e1));
    checkVal("in_ready", 32'(in_ready), 32'(q.size() <= DEPTH - 2));
    if (e0) checkVal("iss0_instr", iss0_instr, q[0]);
    if (e1) checkVal("iss1_instr", iss1_instr, q[1]);
  endtask

  task automatic applyStimulus(input bit rst, input bit fl, input bit st, input bit v,
                               input logic [31:0] a, input logic [31:0] b);
    reset     = rst;
    flush     = fl;
    stall     = st;
    in_valid  = v;
    in_instr0 = a;
    in_instr1 = b;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] randInstr();
    logic [5:0] ops [12];
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h3f, 6'h02};
    op  = ops[$urandom_range(0, 11)];
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 11'($urandom)};
  endfunction

  localparam logic [31:0] ADD1 = 32'h00221820;
  localparam logic [31:0] ADDI = 32'h20270001;
  localparam logic [31:0] ADD2 = 32'h00642820;
  localparam logic [31:0] LW   = 32'h8C240000;
  localparam logic [31:0] SW   = 32'hAC460000;
  localparam logic [31:0] BEQ  = 32'h10220004;

  initial begin
    mLdV      = 1'b0;
    mLdRd     = 5'd0;
    reset     = 1'b1;
    flush     = 1'b0;
    stall     = 1'b0;
    in_valid  = 1'b0;
    in_instr0 = '0;
    in_instr1 = '0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0);
    checkVal("lit_reset_iss0v", 32'(iss0_valid), 32'd0);
    checkVal("lit_reset_iss1v", 32'(iss1_valid), 32'd0);
    checkVal("lit_reset_ready", 32'(in_ready), 32'd1);

    applyStimulus(0, 0, 0, 1, ADD1, ADDI);
    checkVal("lit_indep_iss0v", 32'(iss0_valid), 32'd1);
    checkVal("lit_indep_iss0", iss0_instr, ADD1);
    checkVal("lit_indep_iss1v", 32'(iss1_valid), 32'd1);
    checkVal("lit_indep_iss1", iss1_instr, ADDI);
    idle(1);
    checkVal("lit_indep_empty", 32'(iss0_valid), 32'd0);

    applyStimulus(0, 0, 0, 1, ADD1, ADD2);
    checkVal("lit_raw_c1_iss0", iss0_instr, ADD1);
    checkVal("lit_raw_c1_iss1v", 32'(iss1_valid), 32'd0);
    idle(1);
    checkVal("lit_raw_c2_iss0v", 32'(iss0_valid), 32'd1);
    checkVal("lit_raw_c2_iss0", iss0_instr, ADD2);
    idle(1);

    applyStimulus(0, 0, 0, 1, LW, ADD2);
    checkVal("lit_lu_c1_iss0", iss0_instr, LW);
    checkVal("lit_lu_c1_iss1v", 32'(iss1_valid), 32'd0);
    idle(1);
    checkVal("lit_lu_bubble", 32'(iss0_valid), 32'd0);
    idle(1);
    checkVal("lit_lu_c3_iss0v", 32'(iss0_valid), 32'd1);
    checkVal("lit_lu_c3_iss0", iss0_instr, ADD2);
    idle(1);

    applyStimulus(0, 0, 0, 1, LW, SW);
    checkVal("lit_mem_c1_iss1v", 32'(iss1_valid), 32'd0);
    idle(1);
    checkVal("lit_mem_c2_iss0", iss0_instr, SW);
    checkVal("lit_mem_c2_iss1v", 32'(iss1_valid), 32'd0);
    idle(1);
    applyStimulus(0, 0, 0, 1, BEQ, ADDI);
    checkVal("lit_br_iss0", iss0_instr, BEQ);
    checkVal("lit_br_iss1v", 32'(iss1_valid), 32'd0);
    idle(2);

    applyStimulus(0, 0, 1, 1, ADD1, ADDI);
    checkVal("lit_stall_ready1", 32'(in_ready), 32'd1);
    applyStimulus(0, 0, 1, 1, ADD1, ADDI);
    checkVal("lit_stall_full", 32'(in_ready), 32'd0);
    applyStimulus(0, 0, 1, 1, ADD2, ADD2);
    checkVal("lit_stall_held", 32'(in_ready), 32'd0);
    applyStimulus(0, 0, 0, 1, ADD2, ADD2);
    checkVal("lit_stall_release", 32'(in_ready), 32'd1);
    applyStimulus(0, 0, 0, 1, ADD2, ADD2);
    idle(6);

    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus(0, 0, 0, 1, LW, ADDI);
      applyStimulus(0, 0, 0, 1, ADDI, ADDI);
      applyStimulus(0, 0, 1, 1, ADDI, ADDI);
      applyStimulus(pass == 1, pass == 0, 1, 1, ADD1, ADD1);
      checkVal(pass == 0 ? "lit_flush_iss0v" : "lit_rst_iss0v", 32'(iss0_valid), 32'd0);
      checkVal(pass == 0 ? "lit_flush_ready" : "lit_rst_ready", 32'(in_ready), 32'd1);
      idle(1);
      checkVal(pass == 0 ? "lit_flush_dropped" : "lit_rst_dropped", 32'(iss0_valid), 32'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                    randInstr(), randInstr());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
